// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between
//   two requesters: port A (bus-side memory interface) and port B (a local
//   engine such as DMA or a scrubber). Accesses are serialised through a
//   four-state sequencer (IDLE -> ACC -> [RDLAT] -> ACK). Ties are broken
//   round-robin on a last-served pointer.
//
//   Build option: define SRAM_PORT_ARBITER_FIXED_PRIO_EN for fixed priority
//   (A always wins ties, no pointer, B can starve under continuous A load).
//
// Ports
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   {a,b}_req_i               request, held with wr/addr/data until ack
//   {a,b}_wr_i                1 = write, 0 = read
//   {a,b}_addr_i / _data_i    word address / write data
//   {a,b}_ack_o               1-cycle completion pulse
//   {a,b}_data_o              read data, held until that port's next read
//   sram_addr_o/_data_o/_wr_o registered SRAM bus
//   sram_data_i               SRAM read data, one cycle after address
//   busy_o                    sequencer not idle
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  a_req_i,
  input  logic                  a_wr_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_ack_o,
  output logic [DATA_WIDTH-1:0] a_data_o,
  input  logic                  b_req_i,
  input  logic                  b_wr_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_ack_o,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  sram_wr_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_RDLAT = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;      // 0 = A, 1 = B
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  sram_wr_q, sram_wr_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic                  win_b;

`ifdef SRAM_PORT_ARBITER_FIXED_PRIO_EN
  assign win_b = b_req_i & ~a_req_i;
`else
  // last_q = 1 means B was served last; reset to B so A takes the first tie.
  logic last_q, last_d;
  assign win_b = b_req_i & (~a_req_i | ~last_q);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sram_wr_d = sram_wr_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
`ifndef SRAM_PORT_ARBITER_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (a_req_i | b_req_i) begin
          gnt_d     = win_b;
          wr_d      = win_b ? b_wr_i   : a_wr_i;
          addr_d    = win_b ? b_addr_i : a_addr_i;
          wdata_d   = win_b ? b_data_i : a_data_i;
          sram_wr_d = win_b ? b_wr_i   : a_wr_i;
`ifndef SRAM_PORT_ARBITER_FIXED_PRIO_EN
          last_d    = win_b;
`endif
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        sram_wr_d = 1'b0;
        state_d   = wr_q ? S_ACK : S_RDLAT;
      end
      S_RDLAT: begin
        // Read data arrives now; only the granted port's register updates.
        if (gnt_q) b_data_d = sram_data_i;
        else       a_data_d = sram_data_i;
        state_d = S_ACK;
      end
      default: begin
        // ACK: requests are deliberately not sampled here.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sram_wr_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
`ifndef SRAM_PORT_ARBITER_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sram_wr_q <= sram_wr_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
`ifndef SRAM_PORT_ARBITER_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign a_ack_o     = (state_q == S_ACK) & ~gnt_q;
  assign b_ack_o     = (state_q == S_ACK) &  gnt_q;
  assign a_data_o    = a_data_q;
  assign b_data_o    = b_data_q;
  assign sram_addr_o = addr_q;
  assign sram_data_o = wdata_q;
  assign sram_wr_o   = sram_wr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          sram_wr, busy;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_req_i(a_req), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_ack_o(a_ack), .a_data_o(a_rdata),
    .b_req_i(b_req), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_ack_o(b_ack), .b_data_o(b_rdata),
    .sram_addr_o(sram_addr), .sram_data_o(sram_wdata), .sram_wr_o(sram_wr),
    .sram_data_i(sram_rdata), .busy_o(busy)
  );

  // Behavioural SRAM: write on strobe, read data one cycle after address.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (sram_wr) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: expected completions per port, pushed by the drivers.
  typedef struct { bit wr; logic [DW-1:0] data; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [DW-1:0] refmem [64];
  logic [DW-1:0] exp_a_last, exp_b_last;
  bit mon_en = 0;
  bit prev_wr = 0;
  int wr_pulses = 0;

  always @(negedge clk) if (sram_wr) wr_pulses++;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (a_ack) begin
        if (qa.size() == 0) check("a_spurious_ack", 1, 0);
        else begin
          e = qa.pop_front();
          if (!e.wr) begin
            check("a_rd_data", a_rdata, e.data);
            exp_a_last = e.data;
          end
          check("a_ack_b_data_held", b_rdata, exp_b_last);
        end
      end
      if (b_ack) begin
        if (qb.size() == 0) check("b_spurious_ack", 1, 0);
        else begin
          e = qb.pop_front();
          if (!e.wr) begin
            check("b_rd_data", b_rdata, e.data);
            exp_b_last = e.data;
          end
          check("b_ack_a_data_held", a_rdata, exp_a_last);
        end
      end
      if (sram_wr) begin
        check("wr_only_when_busy", {31'd0, busy}, 1);
        check("wr_single_cycle", {31'd0, prev_wr}, 0);
      end
      prev_wr = sram_wr;
    end
  end

  task automatic wait_ack(input bit pb, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    a_req = 0; b_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Random traffic for one port. Each port uses its own half of the address
  // space so the expected read value follows from that port's program order.
  task automatic drive_port(input bit pb, input int n);
    bit written [32];
    bit got;
    exp_t e;
    logic [AW-1:0] ad;
    for (int i = 0; i < 32; i++) written[i] = 0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      ad = AW'((pb ? 32 : 0) + $urandom_range(0, 31));
      e.wr = !written[ad[4:0]] || ($urandom_range(0, 1) == 1);
      if (e.wr) begin
        refmem[ad] = $urandom;
        written[ad[4:0]] = 1;
      end
      e.data = refmem[ad];
      if (pb) begin
        qb.push_back(e);
        b_wr = e.wr; b_addr = ad; b_data = e.data; b_req = 1;
      end else begin
        qa.push_back(e);
        a_wr = e.wr; a_addr = ad; a_data = e.data; a_req = 1;
      end
      wait_ack(pb, 40, got);
      if (!got) check(pb ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
      if (pb) b_req = 0; else a_req = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit exp_last;   // model pointer: 1 = B served last
    bit exp_win;
    int c0;
    rst_n = 0;
    a_req = 0; a_wr = 0; a_addr = '0; a_data = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_data = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sram_wr", {31'd0, sram_wr}, 0);
    check("rst_sram_addr", {26'd0, sram_addr}, 0);
    check("rst_sram_data", sram_wdata, 0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 0);
    check("rst_a_data", a_rdata, 0);
    check("rst_b_data", b_rdata, 0);

    // A writes DEADBEEF to 0x05: sampled at edge N
    a_wr = 1; a_addr = 6'h05; a_data = 32'hDEADBEEF; a_req = 1;
    @(negedge clk);                       // N+1
    check("aw_sram_addr", {26'd0, sram_addr}, 32'h05);
    check("aw_sram_data", sram_wdata, 32'hDEADBEEF);
    check("aw_sram_wr_n1", {31'd0, sram_wr}, 1);
    check("aw_ack_n1", {31'd0, a_ack}, 0);
    @(negedge clk);                       // N+2
    check("aw_sram_wr_n2", {31'd0, sram_wr}, 0);
    check("aw_ack_n2", {31'd0, a_ack}, 1);
    a_req = 0;
    @(negedge clk);

    // B reads 0x05
    b_wr = 0; b_addr = 6'h05; b_req = 1;
    @(negedge clk);                       // N+1
    check("br_sram_addr", {26'd0, sram_addr}, 32'h05);
    check("br_sram_wr", {31'd0, sram_wr}, 0);
    @(negedge clk);                       // N+2
    check("br_ack_n2", {31'd0, b_ack}, 0);
    @(negedge clk);                       // N+3
    check("br_ack_n3", {31'd0, b_ack}, 1);
    check("br_b_data", b_rdata, 32'hDEADBEEF);
    check("br_a_data_untouched", a_rdata, 0);
    b_req = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset in ACC of a B write
    b_wr = 1; b_addr = 6'h07; b_data = 32'h12345678; b_req = 1;
    @(negedge clk);                       // ACC
    check("mid_rst_in_acc_wr", {31'd0, sram_wr}, 1);
    rst_n = 0; b_req = 0;
    @(negedge clk);
    check("mid_rst_wr_cleared", {31'd0, sram_wr}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_no_ack", {31'd0, b_ack}, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_late_ack", {30'd0, a_ack, b_ack}, 0);
    end

    // Continuous simultaneous requests from fresh reset
    do_reset();
    @(negedge clk);
    a_wr = 1; a_addr = 6'h01; a_data = 32'hAAAA0001; a_req = 1;
    b_wr = 1; b_addr = 6'h21; b_data = 32'hBBBB0001; b_req = 1;
    exp_last = 1;
    for (int k = 0; k < 4; got = 0, k++) begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (a_ack || b_ack) begin got = 1; break; end
      end
      if (!got) check("grant_timeout", 0, 1);
      else begin
`ifdef SRAM_PORT_ARBITER_FIXED_PRIO_EN
        exp_win = 0;
`else
        exp_win = exp_last ? 1'b0 : 1'b1;
        exp_last = exp_win;
`endif
        check("grant_single", {31'd0, a_ack & b_ack}, 0);
        check("grant_order", {31'd0, b_ack}, {31'd0, exp_win});
      end
    end
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);

    // A drops req exactly at ack -> one access
    c0 = wr_pulses;
    a_wr = 1; a_addr = 6'h02; a_data = 32'h0000D00D; a_req = 1;
    wait_ack(0, 20, got);
    check("drop_ack_seen", {31'd0, got}, 1);
    a_req = 0;
    repeat (6) @(negedge clk);
    check("drop_access_count", wr_pulses - c0, 1);

    // A holds req into IDLE -> second access; dropped in ACC still acks
    c0 = wr_pulses;
    a_req = 1;
    wait_ack(0, 20, got);
    check("hold_ack_seen", {31'd0, got}, 1);
    @(negedge clk);                       // IDLE, req still high
    @(negedge clk);                       // ACC of second access
    check("hold_second_acc", {31'd0, sram_wr}, 1);
    a_req = 0;
    wait_ack(0, 10, got);
    check("ack_after_drop_in_acc", {31'd0, got}, 1);
    repeat (4) @(negedge clk);
    check("hold_access_count", wr_pulses - c0, 2);

    // Random interleaved traffic on both ports
    exp_a_last = a_rdata === 32'h0 ? 32'h0 : 32'h0;
    exp_b_last = 32'h0;
    prev_wr = 0;
    mon_en = 1;
    fork
      drive_port(0, 60);
      drive_port(1, 60);
    join
    repeat (6) @(negedge clk);
    mon_en = 0;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
